// File: rtl/comp_stats.sv
// comp_stats: accumulates comparator-result statistics over a window of valid samples.
//
// A start pulse in IDLE clears the tallies and opens a window of `win` valid samples.
// Each accepted sample with exactly one of gt/eq/lt set bumps the matching saturating
// counter; any other flag combination sets the sticky err flag instead. max_a tracks the
// largest operand seen. The sample that completes the window moves the FSM to DONE on
// the same edge it is tallied, giving a one-cycle done pulse before returning to IDLE.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset, priority over start/valid
//   start  in   open a new window (honoured only in IDLE)
//   valid  in   qualifies a/gt/eq/lt this cycle
//   a      in   [n-1:0] operand A fed to the upstream comparator
//   gt     in   comparator flag A > B
//   eq     in   comparator flag A == B
//   lt     in   comparator flag A < B
//   busy   out  window in progress
//   done   out  one-cycle pulse when a window completes
//   gt_cnt out  [cw-1:0] tally of gt samples
//   eq_cnt out  [cw-1:0] tally of eq samples
//   lt_cnt out  [cw-1:0] tally of lt samples
//   max_a  out  [n-1:0] largest a accepted in the current/last window
//   err    out  sticky malformed-flags indicator for the window
module comp_stats #(
    parameter int unsigned n   = 4,
    parameter int unsigned cw  = 8,
    parameter int unsigned win = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          valid,
    input  logic [n-1:0]  a,
    input  logic          gt,
    input  logic          eq,
    input  logic          lt,
    output logic          busy,
    output logic          done,
    output logic [cw-1:0] gt_cnt,
    output logic [cw-1:0] eq_cnt,
    output logic [cw-1:0] lt_cnt,
    output logic [n-1:0]  max_a,
    output logic          err
);

    // Wide enough to hold the value win itself.
    localparam int unsigned iw = $clog2(win + 1);

    localparam logic [iw-1:0] last_idx = iw'(win - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t        state;
    logic [iw-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
            max_a  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= StRun;
                        idx    <= '0;
                        busy   <= 1'b1;
                        gt_cnt <= '0;
                        eq_cnt <= '0;
                        lt_cnt <= '0;
                        max_a  <= '0;
                        err    <= 1'b0;
                    end
                end

                StRun: begin
                    if (valid) begin
                        // Only a clean one-hot result is tallied; anything else
                        // still consumes a slot in the window.
                        case ({gt, eq, lt})
                            3'b100: if (gt_cnt != '1) gt_cnt <= gt_cnt + cw'(1);
                            3'b010: if (eq_cnt != '1) eq_cnt <= eq_cnt + cw'(1);
                            3'b001: if (lt_cnt != '1) lt_cnt <= lt_cnt + cw'(1);
                            default: err <= 1'b1;
                        endcase

                        if (a > max_a) begin
                            max_a <= a;
                        end

                        idx <= idx + iw'(1);
                        if (idx == last_idx) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
